// File: rtl/bit_stream_serializer_if.sv
// Parallel-word handshake plus serial-side status for the bit stream serializer.
// The feeder drives data_in/data_valid; the serializer drives everything else.
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             x;
    logic             x_valid;
    logic             word_done;
    logic             busy;
    logic [9:0]       words_sent;

    modport master (
        output data_in, data_valid,
        input  data_ready, x, x_valid, word_done, busy, words_sent
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, x, x_valid, word_done, busy, words_sent
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: one bit per clock on x, with a one-word holding
// buffer so consecutive words stream with no idle gap between them.
module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    bit_stream_serializer_if.slave bus
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [0:0]        IDLE     = 1'b0;
    localparam logic [0:0]        SHIFT    = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_buf;
    logic             hold_full;
    logic [CNT_W-1:0] bit_cnt;
    logic             x_r;
    logic             x_valid_r;
    logic [9:0]       words_sent_r;
    logic             accept;
    logic             last_bit;

    // Bit that goes onto x first when a word is loaded.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its outgoing bit removed, so first_bit() yields the next one.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit        = (state == SHIFT) && (bit_cnt == '0);
    assign bus.data_ready  = !rst && ((state == IDLE) || !hold_full);
    assign accept          = bus.data_valid && bus.data_ready;
    assign bus.x           = x_r;
    assign bus.x_valid     = x_valid_r;
    assign bus.word_done   = last_bit;
    assign bus.busy        = (state == SHIFT) || hold_full;
    assign bus.words_sent  = words_sent_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_full    <= 1'b0;
            bit_cnt      <= '0;
            x_r          <= IDLE_BIT;
            x_valid_r    <= 1'b0;
            words_sent_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        x_r       <= first_bit(bus.data_in);
                        x_valid_r <= 1'b1;
                        bit_cnt   <= LAST_IDX;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        x_r     <= first_bit(shreg);
                        bit_cnt <= bit_cnt - 1'b1;
                        if (accept) hold_full <= 1'b1;
                    end else begin
                        // Last bit leaves x on this edge: chain the next word if one is ready.
                        words_sent_r <= words_sent_r + 10'd1;
                        if (hold_full) begin
                            x_r       <= first_bit(hold_buf);
                            hold_full <= 1'b0;
                            bit_cnt   <= LAST_IDX;
                        end else if (accept) begin
                            x_r     <= first_bit(bus.data_in);
                            bit_cnt <= LAST_IDX;
                        end else begin
                            state     <= IDLE;
                            x_r       <= IDLE_BIT;
                            x_valid_r <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word storage carries no reset; hold_full and state qualify its contents.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (accept) shreg <= shift_out(bus.data_in);
        end else if (bit_cnt != '0) begin
            shreg <= shift_out(shreg);
            if (accept) hold_buf <= bus.data_in;
        end else if (hold_full) begin
            shreg <= shift_out(hold_buf);
        end else if (accept) begin
            shreg <= shift_out(bus.data_in);
        end
    end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: MSB- and LSB-first instances, with a
// non-overlapping 010 detector model watching each serial stream.
module tb_bit_stream_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_stream_serializer_if #(.WIDTH(W)) bus ();
    bit_stream_serializer_if #(.WIDTH(W)) bus2 ();

    bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] cap      = '0;
    int          run      = 0;
    int          last_run = 0;
    int          wd_cnt   = 0;
    int          det_cnt  = 0;
    int          det2_cnt = 0;
    logic [1:0]  ds       = 2'd0;
    logic [1:0]  ds2      = 2'd0;

    // Returns {hit, next_state}; restarts from scratch after each hit.
    function automatic logic [2:0] det_step(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 3'b000 : 3'b001;
            2'd1:    return b ? 3'b010 : 3'b001;
            2'd2:    return b ? 3'b000 : 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [2:0] r;
        if (bus.x_valid) begin
            r        = det_step(ds, bus.x);
            ds      <= r[1:0];
            det_cnt <= det_cnt + int'(r[2]);
            cap     <= {cap[30:0], bus.x};
            run     <= run + 1;
        end else begin
            ds <= 2'd0;
            if (run != 0) last_run <= run;
            run <= 0;
        end
        if (bus.word_done) wd_cnt <= wd_cnt + 1;
    end

    always @(negedge clk) begin
        logic [2:0] r;
        if (bus2.x_valid) begin
            r         = det_step(ds2, bus2.x);
            ds2      <= r[1:0];
            det2_cnt <= det2_cnt + int'(r[2]);
        end else begin
            ds2 <= 2'd0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic stream(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int n, output int lowcnt);
        int   k;
        logic acc;
        k              = 0;
        lowcnt         = 0;
        bus.data_in    = w0;
        bus.data_valid = 1'b1;
        for (int c = 0; c < 100 && k < n; c++) begin
            acc = bus.data_ready;
            if (!acc) lowcnt++;
            tick();
            if (acc) begin
                k++;
                if (k == 1) bus.data_in = w1;
                if (k == 2) bus.data_in = w2;
                if (k >= n) bus.data_valid = 1'b0;
            end
        end
        chk("stream_accepts", 32'(k), 32'(n));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200 && bus.busy; c++) tick();
        chk("idle_timeout", 32'(bus.busy), 32'd0);
        tick();
    endtask

    initial begin
        int          base;
        int          lowcnt;
        int          nacc;
        int          done_n;
        logic        acc;
        logic        wd;
        logic        seen_valid;
        logic [7:0]  exp_w;

        rst             = 1'b1;
        bus.data_in     = '0;
        bus.data_valid  = 1'b0;
        bus2.data_in    = '0;
        bus2.data_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_x",          32'(bus.x),          32'd1);
        chk("rst_x_valid",    32'(bus.x_valid),    32'd0);
        chk("rst_word_done",  32'(bus.word_done),  32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_words_sent", 32'(bus.words_sent), 32'd0);
        chk("rst_ready",      32'(bus.data_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(bus.data_ready), 32'd1);

        // Single word, MSB first
        base           = det_cnt;
        exp_w          = 8'b0100_1010;
        bus.data_in    = exp_w;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.data_in    = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("single_x[%0d]", i),  32'(bus.x),         32'(exp_w[7-i]));
            chk($sformatf("single_xv[%0d]", i), 32'(bus.x_valid),   32'd1);
            chk($sformatf("single_wd[%0d]", i), 32'(bus.word_done), 32'(i == 7));
            tick();
        end
        chk("single_idle_x",  32'(bus.x),          32'd1);
        chk("single_idle_xv", 32'(bus.x_valid),    32'd0);
        chk("single_sent",    32'(bus.words_sent), 32'd1);
        chk("single_busy",    32'(bus.busy),       32'd0);
        chk("single_det",     32'(det_cnt - base), 32'd2);

        // Back-to-back three words
        do_reset();
        stream(8'hA5, 8'h3C, 8'h81, 3, lowcnt);
        chk("b2b_ready_low", 32'(lowcnt), 32'd7);
        wait_idle();
        chk("b2b_run",  32'(last_run),         32'd24);
        chk("b2b_bits", {8'h00, cap[23:0]},    32'h00A53C81);
        chk("b2b_sent", 32'(bus.words_sent),   32'd3);
        chk("b2b_xv",   32'(bus.x_valid),      32'd0);
        chk("b2b_x",    32'(bus.x),            32'd1);

        // 010 spanning a word boundary
        do_reset();
        base = det_cnt;
        stream(8'b0000_0001, 8'b0111_1111, 8'h00, 2, lowcnt);
        wait_idle();
        chk("bnd_run",  32'(last_run),        32'd16);
        chk("bnd_bits", {16'h0000, cap[15:0]}, 32'h0000017F);
        chk("bnd_det",  32'(det_cnt - base),  32'd1);

        // Reset in the middle of a word with a second word held
        do_reset();
        bus.data_in    = 8'hFF;
        bus.data_valid = 1'b1;
        tick();
        bus.data_in = 8'h55;
        chk("mid_ready_before_hold", 32'(bus.data_ready), 32'd1);
        tick();
        bus.data_valid = 1'b0;
        chk("mid_ready_hold_full", 32'(bus.data_ready), 32'd0);
        tick();
        tick();
        chk("mid_bit4_xv", 32'(bus.x_valid), 32'd1);
        base = wd_cnt;
        rst  = 1'b1;
        #1;
        chk("mid_rst_x",     32'(bus.x),          32'd1);
        chk("mid_rst_xv",    32'(bus.x_valid),    32'd0);
        chk("mid_rst_busy",  32'(bus.busy),       32'd0);
        chk("mid_rst_sent",  32'(bus.words_sent), 32'd0);
        chk("mid_rst_ready", 32'(bus.data_ready), 32'd0);
        chk("mid_rst_wd",    32'(bus.word_done),  32'd0);
        tick();
        chk("mid_rst_ready_hold", 32'(bus.data_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(bus.data_ready), 32'd1);
        chk("mid_rel_busy",  32'(bus.busy),       32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.x_valid) seen_valid = 1'b1;
        end
        chk("mid_held_dropped", 32'(seen_valid),    32'd0);
        chk("mid_no_word_done", 32'(wd_cnt - base), 32'd0);
        chk("mid_sent_after",   32'(bus.words_sent), 32'd0);

        // 1024-word stream wraps words_sent
        do_reset();
        base           = wd_cnt;
        nacc           = 0;
        done_n         = 0;
        bus.data_in    = 8'h5A;
        bus.data_valid = 1'b1;
        for (int c = 0; c < 20000 && done_n < 1024; c++) begin
            acc = bus.data_valid && bus.data_ready;
            wd  = bus.word_done;
            tick();
            if (acc) begin
                nacc++;
                if (nacc == 1024) bus.data_valid = 1'b0;
            end
            if (wd) begin
                done_n++;
                if (done_n == 1023) chk("wrap_sent_1023", 32'(bus.words_sent), 32'd1023);
                if (done_n == 1024) chk("wrap_sent_0",    32'(bus.words_sent), 32'd0);
            end
        end
        chk("wrap_done_n", 32'(done_n), 32'd1024);
        wait_idle();
        chk("wrap_wd_pulses", 32'(wd_cnt - base), 32'd1024);
        chk("wrap_idle_xv",   32'(bus.x_valid),   32'd0);

        // LSB-first instance
        base            = det2_cnt;
        exp_w           = 8'b0000_0010;
        bus2.data_in    = exp_w;
        bus2.data_valid = 1'b1;
        tick();
        bus2.data_valid = 1'b0;
        bus2.data_in    = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_x[%0d]", i),  32'(bus2.x),       32'(exp_w[i]));
            chk($sformatf("lsb_xv[%0d]", i), 32'(bus2.x_valid), 32'd1);
            tick();
        end
        tick();
        chk("lsb_det",  32'(det2_cnt - base),   32'd1);
        chk("lsb_sent", 32'(bus2.words_sent),   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Upstream feeder for the 010 sequence-detector FSM: accepts parallel words over a valid/ready handshake and emits them one bit per clock on serial output x.
- A one-word holding buffer lets back-to-back words stream with no idle gap, so 010 patterns that span word boundaries reach the detector intact.
- Counts completed words so the bench can cross-check the detector's users_count against the stimulus.

Parameters:
WIDTH, 8, word width in bits (legal 2..32)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
IDLE_BIT, 1, value driven on x when no word is in flight

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
data_in  input  WIDTH  parallel word to transmit
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a word this cycle
x  output  1  serial bit stream (registered) to the detector's x input
x_valid  output  1  x carries a data bit (not idle)
word_done  output  1  high during the cycle the last bit of a word is on x
busy  output  1  shift register or holding buffer occupied
words_sent  output  10  count of fully transmitted words, wraps 1023 -> 0

Behaviour:
- Reset (async assert, sync release): x=IDLE_BIT, x_valid=0, word_done=0, busy=0, words_sent=0, holding buffer empty, state IDLE. data_ready is forced low while rst is high. Any in-flight or held word is discarded.
- Accept: a word is accepted on a rising edge where data_valid && data_ready.
- data_ready:
  - IDLE: data_ready=1.
  - SHIFT: data_ready = !hold_full.
- States:
  - IDLE: x=IDLE_BIT, x_valid=0. On accept, the word loads the shift register; x <= first bit; x_valid <= 1; bit_cnt <= WIDTH-1; go to SHIFT.
  - SHIFT, bit_cnt != 0: each edge advances x to the next bit and decrements bit_cnt. An accept in this state writes the holding buffer; hold_full <= 1.
  - SHIFT, bit_cnt == 0: the last bit is on x and word_done=1. On the next edge, words_sent increments and one of the following applies:
    - hold_full: the held word moves to the shift register, x <= its first bit, hold_full <= 0. There is no accept on this edge because data_ready=0.
    - hold empty with a simultaneous accept: the new word goes directly to the shift register. This gives a seamless stream.
    - otherwise: go to IDLE, x <= IDLE_BIT, x_valid <= 0.
- Latency: the first bit of an accepted word appears on x in the cycle after the accepting edge. A word occupies exactly WIDTH consecutive cycles on x.
- Back-to-back: sustained throughput is one word per WIDTH cycles. data_ready drops in the cycle after the holding buffer fills and returns the cycle after it empties.
- Bit order: MSB_FIRST=1 sends data_in[WIDTH-1] down to data_in[0]. MSB_FIRST=0 sends the reverse.
- data_in is sampled only on the accepting edge. Later changes to data_in have no effect.
- busy = (state==SHIFT) || hold_full.
- words_sent is a 10-bit unsigned counter that wraps silently.
- Async reset asserted mid-word truncates the stream immediately: x returns to IDLE_BIT and no word_done is issued.

Test Plan:
- Single word, MSB_FIRST=1: data_in=8'b0100_1010 accepted at edge 0.
  - Required: x = 0,1,0,0,1,0,1,0 in cycles 1..8, x_valid=1 throughout, word_done only in cycle 8.
  - Cycle 9: x=1, x_valid=0, words_sent=1.
  - Downstream detector counts 2 occurrences of 010.
- Back-to-back: three words 8'hA5, 8'h3C, 8'h81 with data_valid held high.
  - Required: 24 contiguous x_valid cycles, no idle bit between words.
  - data_ready low while hold is full.
  - words_sent=3, then IDLE.
- Boundary pattern: words 8'b0000_0001 then 8'b0111_1111 back-to-back.
  - Required: cross-boundary bits 1,0 follow the preceding 0 without a gap, and the detector registers the spanning 010 exactly once.
- Reset mid-word: assert rst during bit 4 of 8'hFF with a second word held.
  - Required: x=1, x_valid=0, busy=0, words_sent=0 at once.
  - Held word dropped; data_ready=0 while rst is high, then 1.
- Wrap: stream 1024 words.
  - Required: words_sent reads 1023 after the 1023rd word, then 0 after the 1024th.
  - word_done pulses 1024 times.
- MSB_FIRST=0, data_in=8'b0000_0010.
  - Required: x = 0,1,0,0,0,0,0,0 in cycles 1..8.
  - Detector sees one 010.
